// File: rtl/pwm_decoder.sv
// pwm_decoder
//   Recovers 8-bit samples from a single-bit PWM stream. Each frame runs from
//   one rising edge to the next. The high time of an in-tolerance frame is
//   emitted as a sample with a one-cycle valid strobe. A frame whose length is
//   out of tolerance raises a one-cycle error strobe instead. A line stuck at
//   one level is reported as a constant 0 or 255, repeated once per nominal
//   period.
//
// Parameters
//   PERIOD      nominal frame length in clk cycles
//   TOL         accepted frame-length deviation, +/- cycles
//   SYNC_STAGES flops in the pwm_in synchronizer (>= 2)
//
// Ports
//   clk          system clock
//   n_rst        asynchronous reset, active-high
//   en           decode enable; when low, decoding stops and outputs hold
//   pwm_in       PWM stream, may be asynchronous to clk
//   sample_out   last decoded sample
//   sample_valid one-cycle strobe when sample_out updates
//   frame_err    one-cycle strobe on an out-of-tolerance frame
//   locked       last closed frame was in tolerance
module pwm_decoder #(
  parameter int PERIOD      = 256,
  parameter int TOL         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic       pwm_in,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic       frame_err,
  output logic       locked
);

  localparam int CW = $clog2(PERIOD + TOL + 1) + 1;

  localparam logic [CW-1:0] LIMIT    = CW'(PERIOD + TOL);
  localparam logic [CW-1:0] LO_BOUND = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] PER_C    = CW'(PERIOD);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] CMAX     = '1;

  localparam logic [1:0] SEEK  = 2'd0;
  localparam logic [1:0] HIGH  = 2'd1;
  localparam logic [1:0] LOW   = 2'd2;
  localparam logic [1:0] CONST = 2'd3;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + ONE;
  endfunction

  // Widened first so the clip works for any counter width.
  function automatic logic [7:0] clip8(input logic [CW-1:0] v);
    logic [CW+7:0] w;
    w = {8'b0, v};
    return (w > (CW + 8)'(255)) ? 8'hFF : w[7:0];
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   pwm_s;
  logic                   pwm_d;
  logic                   rise;
  logic                   fall;

  // Synchronizer and edge-detect stage
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      sync  <= '0;
      pwm_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pwm_in};
      pwm_d <= pwm_s;
    end
  end

  assign pwm_s = sync[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] per_cnt;
  logic [CW-1:0] per_n;
  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] hi_n;
  logic [7:0]    sample_n;
  logic          valid_n;
  logic          err_n;
  logic          locked_n;
  logic          awaited;
  logic          timeout;

  always_comb begin
    state_n  = state;
    per_n    = sat_inc(per_cnt);
    hi_n     = hi_cnt;
    sample_n = sample_out;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    locked_n = locked;
    // The edge each state is waiting for; if it arrives on the LIMIT cycle
    // it wins over the timeout.
    awaited  = (state == HIGH) ? fall : rise;
    timeout  = (state != CONST) && (per_cnt == LIMIT) && !awaited;

    if (!en) begin
      state_n = SEEK;
      per_n   = '0;
      hi_n    = '0;
    end else if (timeout) begin
      sample_n = pwm_s ? 8'hFF : 8'h00;
      valid_n  = 1'b1;
      locked_n = 1'b0;
      state_n  = CONST;
      per_n    = ONE;
    end else begin
      case (state)
        SEEK: begin
          if (rise) begin
            state_n = HIGH;
            per_n   = ONE;
            hi_n    = ONE;
          end
        end
        HIGH: begin
          // The fall cycle itself is already low, so it does not add to the high time.
          if (fall) state_n = LOW;
          else      hi_n    = sat_inc(hi_cnt);
        end
        LOW: begin
          if (rise) begin
            if (per_cnt >= LO_BOUND && per_cnt <= LIMIT) begin
              sample_n = clip8(hi_cnt);
              valid_n  = 1'b1;
              locked_n = 1'b1;
            end else begin
              err_n    = 1'b1;
              locked_n = 1'b0;
            end
            state_n = HIGH;
            per_n   = ONE;
            hi_n    = ONE;
          end
        end
        default: begin
          if (rise) begin
            state_n = HIGH;
            per_n   = ONE;
            hi_n    = ONE;
          end else if (fall) begin
            state_n = SEEK;
            per_n   = ONE;
          end else if (per_cnt == PER_C) begin
            valid_n = 1'b1;
            per_n   = ONE;
          end
        end
      endcase
    end
  end

  // Frame state and output register stage
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state        <= SEEK;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_n;
      per_cnt      <= per_n;
      hi_cnt       <= hi_n;
      sample_out   <= sample_n;
      sample_valid <= valid_n;
      frame_err    <= err_n;
      locked       <= locked_n;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
//   Self-checking bench for pwm_decoder. A timestamp-based reference model
//   (frame start / fall time / reference point per edge) predicts outputs each
//   cycle; directed phases add fixed expected values.
module tb_pwm_decoder;

  localparam int PERIOD      = 256;
  localparam int TOL         = 2;
  localparam int SYNC_STAGES = 2;
  localparam int LIMIT       = PERIOD + TOL;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       en;
  logic       pwm_in;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       frame_err;
  logic       locked;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;
  int ecnt   = 0;

  pwm_decoder #(
    .PERIOD     (PERIOD),
    .TOL        (TOL),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (en),
    .pwm_in      (pwm_in),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_SEEK, M_HIGH, M_LOW, M_CONST} mmode_t;

  mmode_t     mode;
  int         n = 0;      // clock edges seen
  int         org;        // edge at which the elapsed-time reference restarts
  int         fstart;     // edge of the rise that opened the frame
  int         ftime;      // edge of the fall inside the frame
  logic       q[$];       // pwm_in history, newest first
  logic [7:0] m_sample;
  logic       m_valid;
  logic       m_err;
  logic       m_locked;

  task automatic model_reset();
    mode     = M_SEEK;
    org      = n + 1;
    m_sample = 8'd0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_locked = 1'b0;
    q = {};
    for (int i = 0; i <= SYNC_STAGES; i++) q.push_back(1'b0);
  endtask

  task automatic model_edge(input logic p, input logic e);
    logic s, d, rise, fall, tmo;
    int   age, len, hi;
    n++;
    if (n_rst) begin
      model_reset();
      return;
    end
    // Decoder sees pwm_in as sampled SYNC_STAGES edges earlier.
    s = q[SYNC_STAGES-1];
    d = q[SYNC_STAGES];
    q.push_front(p);
    q.delete(SYNC_STAGES + 1);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!e) begin
      mode = M_SEEK;
      org  = n + 1;
      return;
    end
    age  = n - org;
    rise = s && !d;
    fall = !s && d;
    tmo  = 1'b0;
    case (mode)
      M_SEEK: begin
        if (rise) begin mode = M_HIGH; fstart = n; org = n; end
        else if (age == LIMIT) tmo = 1'b1;
      end
      M_HIGH: begin
        if (fall) begin mode = M_LOW; ftime = n; end
        else if (age == LIMIT) tmo = 1'b1;
      end
      M_LOW: begin
        if (rise) begin
          len = age;
          hi  = ftime - fstart;
          if (len >= PERIOD - TOL && len <= PERIOD + TOL) begin
            m_sample = (hi > 255) ? 8'd255 : 8'(hi);
            m_valid  = 1'b1;
            m_locked = 1'b1;
          end else begin
            m_err    = 1'b1;
            m_locked = 1'b0;
          end
          mode = M_HIGH; fstart = n; org = n;
        end else if (age == LIMIT) tmo = 1'b1;
      end
      default: begin
        if (rise) begin mode = M_HIGH; fstart = n; org = n; end
        else if (fall) begin mode = M_SEEK; org = n; end
        else if (age == PERIOD) begin m_valid = 1'b1; org = n; end
      end
    endcase
    if (tmo) begin
      m_sample = s ? 8'd255 : 8'd0;
      m_valid  = 1'b1;
      m_locked = 1'b0;
      mode     = M_CONST;
      org      = n;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic p, input logic e);
    pwm_in = p;
    en     = e;
    @(posedge clk);
    model_edge(p, e);
    @(negedge clk);
    if (sample_valid) vcnt++;
    if (frame_err)    ecnt++;
    check("cycle", {21'd0, sample_out, sample_valid, frame_err, locked},
          {21'd0, m_sample, m_valid, m_err, m_locked});
  endtask

  task automatic frame(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b1);
    repeat (lo) step(1'b0, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    n_rst = 1'b1;
    model_reset();
    #1;
    check("rst_async", {24'd0, sample_out, sample_valid, frame_err, locked}, 32'd0);
    for (int i = 0; i < cycles; i++) step(1'(i & 1), 1'b1);
    n_rst = 1'b0;
  endtask

  initial begin
    n_rst  = 1'b0;
    en     = 1'b0;
    pwm_in = 1'b0;
    #10;
    do_reset(4);

    // Ideal stream, duty 100 / 1 / 255
    vcnt = 0;
    repeat (4) frame(100, 156);
    check("ideal_cnt", vcnt, 3);
    check("ideal_val", {24'd0, sample_out}, 100);
    check("ideal_lock", {31'd0, locked}, 1);
    vcnt = 0;
    repeat (3) frame(1, 255);
    check("duty1_cnt", vcnt, 3);
    check("duty1_val", {24'd0, sample_out}, 1);
    repeat (3) frame(255, 1);
    check("duty255_val", {24'd0, sample_out}, 255);

    // Constant low after reset, then constant high after lock
    do_reset(3);
    vcnt = 0;
    repeat (800) step(1'b0, 1'b1);
    check("low_cnt", vcnt, 3);
    check("low_val", {24'd0, sample_out}, 0);
    check("low_lock", {31'd0, locked}, 0);
    repeat (3) frame(100, 156);
    check("relock", {31'd0, locked}, 1);
    vcnt = 0;
    repeat (800) step(1'b1, 1'b1);
    check("high_cnt", vcnt, 4);
    check("high_val", {24'd0, sample_out}, 255);
    check("high_lock", {31'd0, locked}, 0);

    // Tolerance: 254 and 258 accepted, 253 rejected, 256 relocks
    do_reset(3);
    ecnt = 0;
    frame(100, 156);
    frame(90, 164);
    frame(80, 178);
    frame(70, 183);
    repeat (3) step(1'b1, 1'b1);
    check("tol_err_cnt", ecnt, 1);
    check("tol_hold_val", {24'd0, sample_out}, 80);
    check("tol_unlock", {31'd0, locked}, 0);
    repeat (57) step(1'b1, 1'b1);
    repeat (196) step(1'b0, 1'b1);
    frame(50, 206);
    check("tol_relock_val", {24'd0, sample_out}, 60);
    check("tol_relock", {31'd0, locked}, 1);

    // Enable dropped mid-frame
    frame(100, 156);
    frame(100, 156);
    repeat (100) step(1'b1, 1'b1);
    vcnt = 0;
    repeat (50) step(1'b0, 1'b0);
    check("en_nostrobe", vcnt, 0);
    check("en_hold_val", {24'd0, sample_out}, 100);
    check("en_hold_lock", {31'd0, locked}, 1);
    repeat (106) step(1'b0, 1'b1);
    frame(100, 156);
    check("en_skip", vcnt, 0);
    frame(30, 226);
    check("en_resume", vcnt, 1);

    // Reset mid-frame while locked
    repeat (30) step(1'b1, 1'b1);
    do_reset(3);
    vcnt = 0;
    frame(100, 156);
    check("rst_align", vcnt, 0);
    frame(100, 156);
    check("rst_first", vcnt, 1);

    // Randomized frames, stuck levels and enable drops
    for (int i = 0; i < 40; i++) begin
      int   kind, per, hi, len, off;
      logic lvl;
      kind = $urandom_range(0, 9);
      per  = $urandom_range(PERIOD - 4, PERIOD + 4);
      hi   = $urandom_range(1, per - 1);
      if (kind < 7) begin
        frame(hi, per - hi);
      end else if (kind == 7) begin
        len = $urandom_range(300, 700);
        lvl = 1'($urandom_range(0, 1));
        repeat (len) step(lvl, 1'b1);
      end else begin
        off = $urandom_range(1, 60);
        repeat (hi) step(1'b1, 1'b1);
        repeat (off) step(1'b0, 1'b0);
        repeat (per - hi) step(1'b0, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
